// File: rtl/flash_boot_copier.sv
// flash_boot_copier: copies QWCNT qwords from SPI flash through the flash controller into destination memory.
module flash_boot_copier #(
    parameter logic [7:0] RDINST = 8'h03,
    parameter int         TMO    = 4096
) (
    input  logic        CLKH,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] SRCADDR,
    input  logic [31:0] DSTADDR,
    input  logic [15:0] QWCNT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    input  logic        NEXT,
    output logic        ACT,
    output logic        CMD,
    output logic [31:0] ADDR,
    output logic [7:0]  BE,
    output logic [63:0] DTI,
    output logic [20:0] TAGI,
    input  logic        DRDY,
    input  logic [63:0] DTO,
    input  logic [20:0] TAGO,
    output logic        MACT,
    input  logic        MNEXT,
    output logic [31:0] MADDR,
    output logic [63:0] MDTO
);
    typedef enum logic [2:0] {IDLE, SETINST, RDREQ, RDWAIT, WRMEM, FIN} state_t;
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);
    state_t state_q, state_d;
    logic [28:0] src_q, src_d;
    logic [31:0] dst_q, dst_d, addr_q, addr_d, maddr_q, maddr_d;
    logic [15:0] rem_q, rem_d, seq_q, seq_d, tmo_q, tmo_d;
    logic [63:0] dti_q, dti_d, mdto_q, mdto_d;
    logic [20:0] tagi_q, tagi_d;
    logic [7:0]  be_q, be_d;
    logic        err_q, err_d, done_q, done_d, act_q, act_d, cmd_q, cmd_d, mact_q, mact_d;
    logic        unused_ok;
    assign unused_ok = ^{SRCADDR[31:29], SRCADDR[2:0], DSTADDR[2:0], TAGO[20:16]};
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (START) begin
                src_d   = {SRCADDR[28:3], 3'b000};
                dst_d   = {DSTADDR[31:3], 3'b000};
                rem_d   = QWCNT;
                seq_d   = '0;
                err_d   = 1'b0;
                state_d = (QWCNT == '0) ? FIN : SETINST;
            end
            SETINST: state_d = (act_q && NEXT) ? RDREQ : SETINST;
            RDREQ:   state_d = (act_q && NEXT) ? RDWAIT : RDREQ;
            RDWAIT: begin
                if (DRDY) begin
                    state_d = (TAGO[15:0] == seq_q) ? WRMEM : IDLE;
                    err_d   = (TAGO[15:0] != seq_q);
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WRMEM: if (mact_q && MNEXT) begin
                src_d   = src_q + 29'd8;
                dst_d   = dst_q + 32'd8;
                seq_d   = seq_q + 16'd1;
                rem_d   = rem_q - 16'd1;
                state_d = (rem_q == 16'd1) ? FIN : RDREQ;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tmo_d   = (state_q == RDWAIT && state_d == RDWAIT) ? tmo_q + 16'd1 : '0;
        // a request drops for one cycle after acceptance so back-to-back requests never merge
        act_d   = (state_d == SETINST || state_d == RDREQ) && !(act_q && NEXT);
        cmd_d   = act_d ? (state_d == RDREQ) : cmd_q;
        addr_d  = act_d ? ((state_d == RDREQ) ? {3'b001, src_d[28:3], 3'b000} : 32'h0100_0000) : addr_q;
        be_d    = act_d ? ((state_d == RDREQ) ? 8'hFF : 8'hFB) : be_q;
        dti_d   = (act_d && state_d == SETINST) ? {40'b0, RDINST, 16'b0} : dti_q;
        tagi_d  = (act_d && state_d == RDREQ) ? {5'b00011, seq_d} : tagi_q;
        mact_d  = (state_d == WRMEM) && !(mact_q && MNEXT);
        maddr_d = mact_d ? {dst_d[31:3], 3'b000} : maddr_q;
        mdto_d  = (state_q == RDWAIT && state_d == WRMEM) ? DTO : mdto_q;
        done_d  = (state_q == FIN);
    end
    always_ff @(posedge CLKH or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            seq_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            act_q   <= 1'b0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= 8'hFF;
            dti_q   <= '0;
            tagi_q  <= '0;
            mact_q  <= 1'b0;
            maddr_q <= '0;
            mdto_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            done_q  <= done_d;
            act_q   <= act_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            dti_q   <= dti_d;
            tagi_q  <= tagi_d;
            mact_q  <= mact_d;
            maddr_q <= maddr_d;
            mdto_q  <= mdto_d;
        end
    end
    assign BUSY  = (state_q != IDLE);
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign ACT   = act_q;
    assign CMD   = cmd_q;
    assign ADDR  = addr_q;
    assign BE    = be_q;
    assign DTI   = dti_q;
    assign TAGI  = tagi_q;
    assign MACT  = mact_q;
    assign MADDR = maddr_q;
    assign MDTO  = mdto_q;
endmodule

// File: tb/tb_flash_boot_copier.sv
// tb_flash_boot_copier: scoreboard bench with a flash-controller model and a destination-memory monitor.
module tb_flash_boot_copier;
    localparam int TMO = 40;
    logic        CLKH = 0, RESET = 0, START = 0, NEXT = 1, DRDY = 0, MNEXT = 1;
    logic [31:0] SRCADDR = 0, DSTADDR = 0;
    logic [15:0] QWCNT = 0;
    logic [63:0] DTO = 0;
    logic [20:0] TAGO = 0;
    logic        BUSY, DONE, ERR, ACT, CMD, MACT;
    logic [31:0] ADDR, MADDR;
    logic [7:0]  BE;
    logic [63:0] DTI, MDTO;
    logic [20:0] TAGI;
    int total = 0, bad = 0, cyc = 0, rd_cnt = 0, si_cnt = 0, mwr_cnt = 0, rd_cyc = 0;
    bit drop = 0, tag_bad = 0, bp = 0, pend = 0;
    int pdly = 0, dly_cfg = 2;
    logic [20:0] ptag;
    logic [31:0] paddr;
    logic [31:0] rdq[$], wq[$];
    logic [20:0] tgq[$];
    logic [63:0] dq[$];

    flash_boot_copier #(.RDINST(8'h03), .TMO(TMO)) dut (
        .CLKH(CLKH), .RESET(RESET), .START(START), .SRCADDR(SRCADDR), .DSTADDR(DSTADDR),
        .QWCNT(QWCNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .NEXT(NEXT), .ACT(ACT),
        .CMD(CMD), .ADDR(ADDR), .BE(BE), .DTI(DTI), .TAGI(TAGI), .DRDY(DRDY), .DTO(DTO),
        .TAGO(TAGO), .MACT(MACT), .MNEXT(MNEXT), .MADDR(MADDR), .MDTO(MDTO)
    );

    always #5 CLKH = ~CLKH;
    always @(posedge CLKH) cyc++;

    function automatic logic [63:0] fdat(input logic [31:0] a);
        return {~a, a ^ 32'h5A5A_0000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // flash controller model: answers each accepted read after dly_cfg cycles
    always @(posedge CLKH) begin
        #1;
        DRDY = 0;
        if (pend) begin
            if (pdly == 0) begin
                DRDY = 1;
                TAGO = tag_bad ? ptag + 21'd1 : ptag;
                DTO  = fdat(paddr);
                pend = 0;
            end else pdly--;
        end
        MNEXT = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge CLKH) if (RESET) begin
        if (ACT && NEXT) begin
            if (!CMD) begin
                chk("si_addr", ADDR, 32'h0100_0000);
                chk("si_be", BE, 8'hFB);
                chk("si_dti", DTI, 64'h0000_0000_0003_0000);
                si_cnt++;
            end else begin
                chk("rd_addr", ADDR, rdq.size() ? rdq.pop_front() : 32'hDEAD_BEEF);
                chk("rd_tag", TAGI, tgq.size() ? tgq.pop_front() : 21'h1F_FFFF);
                rd_cnt++;
                rd_cyc = cyc;
                if (!drop) begin
                    pend = 1; ptag = TAGI; paddr = ADDR; pdly = dly_cfg;
                end
            end
        end
        if (MACT && MNEXT) begin
            chk("wr_addr", MADDR, wq.size() ? wq.pop_front() : 32'hDEAD_BEEF);
            chk("wr_data", MDTO, dq.size() ? dq.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF);
            mwr_cnt++;
        end
    end

    task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input bit wr);
        logic [28:0] so;
        logic [31:0] dd;
        so = {s[28:3], 3'b000};
        dd = {d[31:3], 3'b000};
        for (int i = 0; i < int'(n); i++) begin
            rdq.push_back({3'b001, so[28:3], 3'b000});
            tgq.push_back({5'b00011, 16'(i)});
            if (wr) begin
                wq.push_back(dd);
                dq.push_back(fdat({3'b001, so[28:3], 3'b000}));
            end
            so = so + 29'd8;
            dd = dd + 32'd8;
        end
        @(posedge CLKH); #1;
        START = 1; SRCADDR = s; DSTADDR = d; QWCNT = n;
        @(posedge CLKH); #1;
        START = 0; SRCADDR = $urandom; DSTADDR = $urandom; QWCNT = 16'($urandom);
        @(negedge CLKH);
        chk("busy_start", BUSY, 1);
        chk("err_clr", ERR, 0);
        chk("act_lat", ACT, n != 0);
        chk("done_early", DONE, 0);
    endtask

    task automatic wait_done(input int maxc);
        int k = 0;
        while (!DONE && k < maxc) begin
            @(negedge CLKH);
            k++;
        end
        chk("done_seen", DONE, 1);
        chk("busy_at_done", BUSY, 0);
        chk("err_at_done", ERR, 0);
        chk("rdq_left", rdq.size(), 0);
        chk("wq_left", wq.size(), 0);
    endtask

    task automatic wait_err(input int maxc);
        int k = 0;
        while (!ERR && k < maxc) begin
            @(negedge CLKH);
            k++;
        end
        chk("err_seen", ERR, 1);
        chk("busy_at_err", BUSY, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r0, s0, w0;
        repeat (3) @(posedge CLKH);
        @(negedge CLKH);
        chk("rst_busy", BUSY, 0); chk("rst_done", DONE, 0); chk("rst_err", ERR, 0);
        chk("rst_act", ACT, 0); chk("rst_mact", MACT, 0); chk("rst_cmd", CMD, 0);
        chk("rst_be", BE, 8'hFF); chk("rst_addr", ADDR, 0); chk("rst_dti", DTI, 0);
        chk("rst_tagi", TAGI, 0); chk("rst_maddr", MADDR, 0); chk("rst_mdto", MDTO, 0);
        @(posedge CLKH); #1 RESET = 1;

        do_copy(32'h100, 32'h8000, 3, 1);
        wait_done(200);
        chk("basic_si", si_cnt, 1); chk("basic_rd", rd_cnt, 3); chk("basic_wr", mwr_cnt, 3);

        r0 = rd_cnt; s0 = si_cnt;
        do_copy(32'h40, 32'h80, 0, 1);
        @(negedge CLKH); chk("z_busy", BUSY, 0); chk("z_done", DONE, 1);
        @(negedge CLKH); chk("z_done_off", DONE, 0);
        chk("z_no_si", si_cnt, s0); chk("z_no_rd", rd_cnt, r0);

        NEXT = 0;
        do_copy(32'h200, 32'h9000, 1, 1);
        chk("st_si_cmd", CMD, 0);
        @(posedge CLKH); #1 NEXT = 1;
        @(posedge CLKH); #1 NEXT = 0;
        k = 0;
        @(negedge CLKH);
        while (!ACT && k < 20) begin @(negedge CLKH); k++; end
        r0 = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("st_act", ACT, 1);
            chk("st_addr", ADDR, 32'h2000_0200);
            @(negedge CLKH);
        end
        @(posedge CLKH); #1 NEXT = 1;
        wait_done(100);
        chk("st_one_acc", rd_cnt - r0, 1);

        drop = 1; w0 = mwr_cnt;
        do_copy(32'h400, 32'hA000, 1, 0);
        wait_err(200);
        chk("tmo_cyc", cyc - rd_cyc, TMO + 1);
        chk("tmo_no_wr", mwr_cnt, w0);
        drop = 0;

        tag_bad = 1; w0 = mwr_cnt;
        do_copy(32'h500, 32'hB000, 1, 0);
        wait_err(50);
        chk("tag_no_wr", mwr_cnt, w0);
        tag_bad = 0;
        do_copy(32'h600, 32'hC000, 1, 1);
        wait_done(100);

        bp = 1;
        do_copy(32'h1FFF_FFF8, 32'hFFFF_FFF8, 2, 1);
        wait_done(300);
        do_copy(32'h0000_0107, 32'h0000_2005, 4, 1);
        wait_done(400);
        bp = 0;

        dly_cfg = 8; r0 = rd_cnt;
        do_copy(32'h700, 32'hD000, 2, 1);
        k = 0;
        while (rd_cnt == r0 && k < 50) begin @(negedge CLKH); k++; end
        @(posedge CLKH); #1 RESET = 0;
        #1 chk("mid_rst_busy", BUSY, 0); chk("mid_rst_act", ACT, 0);
        @(posedge CLKH); #1 RESET = 1;
        rdq.delete(); tgq.delete(); wq.delete(); dq.delete();
        w0 = mwr_cnt; r0 = rd_cnt;
        repeat (15) @(negedge CLKH);
        chk("stale_no_wr", mwr_cnt, w0); chk("stale_no_rd", rd_cnt, r0);
        chk("stale_busy", BUSY, 0); chk("stale_err", ERR, 0);
        dly_cfg = 2;
        do_copy(32'h800, 32'hE000, 1, 1);
        wait_done(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flash_boot_copier.md
FLASH_BOOT_COPIER -- requirements
Module: flash_boot_copier

Interface
REQ-001 SHALL have parameter RDINST, default 8'h03, SPI read instruction loaded into the flash controller before copying.
REQ-002 SHALL have parameter TMO, default 4096, cycles to wait for DRDY before abort (16-bit counter).
REQ-003 CLKH  in  1  sole clock; all state changes on its rising edge.
REQ-004 RESET  in  1  reset; asynchronous, active-low.
REQ-005 START  in  1  one-cycle copy request.
REQ-006 SRCADDR  in  32  flash byte offset; bits [2:0] ignored (qword aligned).
REQ-007 DSTADDR  in  32  destination byte address; bits [2:0] ignored.
REQ-008 QWCNT  in  16  number of qwords to copy.
REQ-009 BUSY  out  1  copy in progress.
REQ-010 DONE  out  1  one-cycle pulse at successful completion.
REQ-011 ERR  out  1  sticky error flag; cleared by the next accepted START.
REQ-012 NEXT  in  1  flash controller ready to accept a request.
REQ-013 ACT / CMD  out  1 / 1  request valid / 1=read, 0=write.
REQ-014 ADDR  out  32  request address.
REQ-015 BE  out  8  active-low byte enables (write only).
REQ-016 DTI  out  64  write data.
REQ-017 TAGI  out  21  request tag.
REQ-018 DRDY / DTO / TAGO  in  1 / 64 / 21  read return strobe, data, tag.
REQ-019 MACT  out  1  destination write valid.
REQ-020 MNEXT  in  1  destination accepts write when MACT&MNEXT.
REQ-021 MADDR / MDTO  out  32 / 64  destination address / data.

Function
REQ-022 SHALL implement states IDLE, SETINST, RDREQ, RDWAIT, WRMEM, FIN.
REQ-023 IDLE: START latches SRCADDR, DSTADDR, QWCNT, clears ERR and goes to SETINST; QWCNT==0 goes to FIN instead, with no flash requests issued.
REQ-024 START while BUSY SHALL be ignored.
REQ-025 SETINST: ACT=1, CMD=0, ADDR=32'h0100_0000, BE=8'hFB, DTI[23:16]=RDINST, all other DTI bits 0; held until NEXT=1, then goes to RDREQ.
REQ-026 RDREQ: ACT=1, CMD=1, ADDR={3'b001, src[28:3], 3'b000}, TAGI={3'b000, 2'b11, seq[15:0]}; held until NEXT=1, then goes to RDWAIT.
REQ-027 ACT SHALL drop in the cycle after acceptance; at most one request outstanding.
REQ-028 RDWAIT: on DRDY with TAGO[15:0]==seq, captures DTO and goes to WRMEM.
REQ-029 RDWAIT: on DRDY with a mismatched tag, sets ERR and returns to IDLE.
REQ-030 RDWAIT: timeout counter clears on entry and increments each cycle; reaching TMO sets ERR and returns to IDLE.
REQ-031 WRMEM: MACT=1, MADDR={dst[31:3], 3'b000}, MDTO=captured data; held until MNEXT=1.
REQ-032 On WRMEM handshake: src+=8, dst+=8, seq+=1, remaining-=1; remaining==0 goes to FIN, else RDREQ.
REQ-033 src offset arithmetic SHALL be 29 bits, wrapping modulo 2^29 inside the flash window; dst wraps modulo 2^32.
REQ-034 FIN: DONE=1 for one cycle, then IDLE.
REQ-035 BUSY=1 in every state except IDLE.
REQ-036 seq SHALL reset to 0 at START.
REQ-037 DRDY arriving outside RDWAIT SHALL be ignored.
REQ-038 ACT, MACT and address/data outputs SHALL be registered; request latency START->first ACT is 1 cycle.

Reset
REQ-039 RESET low SHALL force IDLE asynchronously, with BUSY=DONE=ERR=ACT=MACT=0, CMD=0, BE=8'hFF, ADDR=DTI=TAGI=MADDR=MDTO=0, counters 0.
REQ-040 Reset mid-copy SHALL abandon the transfer; a later DRDY for a stale tag SHALL be ignored.

Verification
REQ-041 START, SRCADDR=0x100, DSTADDR=0x8000, QWCNT=3, NEXT=MNEXT=1, model returns tag-matched data -> one SETINST write (DTI[23:16]=03), reads at 0x20000100/108/110, writes to 0x8000/8008/8010, DONE pulse, ERR=0.
REQ-042 QWCNT=0 -> no ACT, DONE pulses 2 cycles after START, BUSY high 1 cycle.
REQ-043 NEXT held low for 10 cycles during RDREQ -> ACT/ADDR stable throughout, single acceptance.
REQ-044 DRDY never returned -> ERR=1 after TMO cycles in RDWAIT, BUSY=0, no MACT.
REQ-045 DRDY with TAGO[15:0]=seq+1 -> ERR=1, IDLE; next START clears ERR.
REQ-046 SRCADDR=0x1FFF_FFF8, QWCNT=2 -> second read at 0x20000000 (wrap).
